// File: rtl/jpeg_byte_stuffer.sv
// Serializes packed 32-bit JPEG entropy-coded words into a byte stream.
// It inserts a 0x00 after each 0xFF data byte, pads the final byte with 1s, and appends EOI (FF D9).
module jpeg_byte_stuffer #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          word_valid,
  input  logic [31:0]                   word_in,
  input  logic                          last_valid,
  input  logic [4:0]                    last_bits,
  output logic [7:0]                    byte_out,
  output logic                          byte_valid,
  input  logic                          byte_ready,
  output logic                          done,
  output logic                          overflow,
  output logic                          proto_err,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int EW = 39;

  typedef enum logic [2:0] {
    S_IDLE, S_EMIT, S_STUFF, S_PAD, S_EOI_FF, S_EOI_D9
  } state_t;

  state_t state, state_nxt;

  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] level;
  logic [EW-1:0] entry_in, head;
  logic          push_req, push, pop, full, empty;

  logic [31:0]   sr;
  logic [5:0]    bits_left, adv_bits;
  logic          last;
  logic [7:0]    top_byte, pad_val;
  logic          accept;

  function automatic logic [7:0] pad_byte(input logic [7:0] b, input logic [5:0] nb);
    return b | (8'hFF >> nb[2:0]);
  endfunction

  function automatic state_t after_advance(input logic [5:0] nb, input logic lst);
    if (nb >= 6'd8)      return S_EMIT;
    else if (nb == 6'd0) return lst ? S_EOI_FF : S_IDLE;
    else                 return S_PAD;
  endfunction

  // Input FIFO: {last, nbits[5:0], data[31:0]}
  assign push_req = word_valid | last_valid;
  assign entry_in = last_valid ? {1'b1, {1'b0, last_bits}, word_in}
                               : {1'b0, 6'd32, word_in};
  assign full     = (level == LW'(FIFO_DEPTH));
  assign empty    = (level == '0);
  assign pop      = (state == S_IDLE) && !empty;
  assign push     = push_req && (!full || pop);
  assign head     = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= entry_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      overflow  <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
      if (push_req && full && !pop)  overflow  <= 1'b1;
      if (word_valid && last_valid)  proto_err <= 1'b1;
    end
  end

  assign fifo_level = level;

  // Byte serializer
  assign top_byte = sr[31:24];
  assign pad_val  = pad_byte(top_byte, bits_left);
  assign adv_bits = (bits_left >= 6'd8) ? (bits_left - 6'd8) : 6'd0;
  assign accept   = byte_valid && byte_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (!empty) begin
          if (head[37:32] >= 6'd8)      state_nxt = S_EMIT;
          else if (head[37:32] != 6'd0) state_nxt = S_PAD;
          else                          state_nxt = S_EOI_FF;
        end
      end
      S_EMIT: begin
        if (accept) state_nxt = (top_byte == 8'hFF) ? S_STUFF : after_advance(adv_bits, last);
      end
      S_STUFF: begin
        if (accept) state_nxt = after_advance(adv_bits, last);
      end
      S_PAD: begin
        if (accept) state_nxt = (pad_val == 8'hFF) ? S_STUFF : S_EOI_FF;
      end
      S_EOI_FF: begin
        if (accept) state_nxt = S_EOI_D9;
      end
      S_EOI_D9: begin
        if (accept) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    byte_valid = 1'b1;
    byte_out   = 8'h00;
    unique case (state)
      S_IDLE:   byte_valid = 1'b0;
      S_EMIT:   byte_out   = top_byte;
      S_STUFF:  byte_out   = 8'h00;
      S_PAD:    byte_out   = pad_val;
      S_EOI_FF: byte_out   = 8'hFF;
      S_EOI_D9: byte_out   = 8'hD9;
      default:  byte_valid = 1'b0;
    endcase
  end

  // A padded 0xFF is stuffed with bits_left cleared, so the STUFF exit lands on EOI_FF
  always_ff @(posedge clk) begin
    unique case (state)
      S_IDLE: begin
        if (pop) begin
          sr        <= head[31:0];
          bits_left <= head[37:32];
          last      <= head[38];
        end
      end
      S_EMIT: begin
        if (accept && top_byte != 8'hFF) begin
          sr        <= sr << 8;
          bits_left <= adv_bits;
        end
      end
      S_STUFF: begin
        if (accept) begin
          sr        <= sr << 8;
          bits_left <= adv_bits;
        end
      end
      S_PAD: begin
        if (accept && pad_val == 8'hFF) bits_left <= 6'd0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) done <= 1'b0;
    else     done <= (state == S_EOI_D9) && accept;
  end

endmodule
